// File: rtl/pc_gen.sv
// pc_gen: fetch program counter with boot state and one-entry pending-redirect buffer
module pc_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] INIT_PC = 32'hbfc00000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_pc,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] exc_pc,
  input  logic                  branch_flag,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  addr_err,
  output logic                  pending_valid
);
  typedef enum logic {BOOT, RUN} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] pending_target;
  // pc update: flush > stall (buffer any branch) > branch > buffered redirect > sequential
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc             <= INIT_PC;
      pending_valid  <= 1'b0;
      pending_target <= '0;
      state          <= BOOT;
    end else if (state == BOOT) begin
      pc    <= flush ? exc_pc : INIT_PC;
      state <= RUN;
    end else if (flush) begin
      pc            <= exc_pc;
      pending_valid <= 1'b0;
    end else if (stall_pc) begin
      if (branch_flag) begin
        pending_valid  <= 1'b1;
        pending_target <= branch_target;
      end
    end else if (branch_flag) begin
      pc            <= branch_target;
      pending_valid <= 1'b0;
    end else if (pending_valid) begin
      pc            <= pending_target;
      pending_valid <= 1'b0;
    end else begin
      pc <= pc + ADDR_WIDTH'(4);
    end
  end
  // fetch outputs derive only from registered pc and state
  always_comb begin
    rom_addr = pc;
    addr_err = (state == RUN) && (pc[1:0] != 2'b00);
    rom_en   = (state == RUN) && !addr_err;
  end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: table-driven scoreboard bench for pc_gen
module tb_pc_gen;
  logic        clk;
  logic        rst;
  logic        stall_pc;
  logic        flush;
  logic [31:0] exc_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic        rom_en;
  logic [31:0] rom_addr;
  logic        addr_err;
  logic        pending_valid;

  pc_gen dut (
    .clk(clk), .rst(rst), .stall_pc(stall_pc), .flush(flush), .exc_pc(exc_pc),
    .branch_flag(branch_flag), .branch_target(branch_target), .pc(pc),
    .rom_en(rom_en), .rom_addr(rom_addr), .addr_err(addr_err),
    .pending_valid(pending_valid)
  );

  typedef struct {
    logic        r, s, f, b;
    logic [31:0] e, t;
    logic [31:0] p;
    logic        en, err, pv;
  } vec_t;

  typedef struct {
    logic [31:0] p;
    logic        en, err, pv;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   applied = 0;
  int   miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic s, logic f, logic [31:0] e, logic b,
                              logic [31:0] t, logic [31:0] p, logic en, logic err, logic pv);
    vec_t v;
    v.r = r; v.s = s; v.f = f; v.e = e; v.b = b; v.t = t;
    v.p = p; v.en = en; v.err = err; v.pv = pv;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    exp_t x;
    exp_t got;
    rst = v.r; stall_pc = v.s; flush = v.f; exc_pc = v.e;
    branch_flag = v.b; branch_target = v.t;
    x.p = v.p; x.en = v.en; x.err = v.err; x.pv = v.pv;
    sb.push_back(x);
    @(posedge clk);
    #1;
    applied++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL vec%0d scoreboard empty", idx);
    end else begin
      got = sb.pop_front();
      if (pc !== got.p) begin
        miscompares++;
        $display("FAIL vec%0d pc got %h expected %h", idx, pc, got.p);
      end
      if (rom_addr !== got.p) begin
        miscompares++;
        $display("FAIL vec%0d rom_addr got %h expected %h", idx, rom_addr, got.p);
      end
      if (rom_en !== got.en) begin
        miscompares++;
        $display("FAIL vec%0d rom_en got %b expected %b", idx, rom_en, got.en);
      end
      if (addr_err !== got.err) begin
        miscompares++;
        $display("FAIL vec%0d addr_err got %b expected %b", idx, addr_err, got.err);
      end
      if (pending_valid !== got.pv) begin
        miscompares++;
        $display("FAIL vec%0d pending_valid got %b expected %b", idx, pending_valid, got.pv);
      end
    end
  endtask

  initial begin
    rst = 1'b0; stall_pc = 1'b0; flush = 1'b0; exc_pc = '0;
    branch_flag = 1'b0; branch_target = '0;
    //            r  s  f  exc           b  target        pc            en err pv
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'hbfc00000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'hbfc00000, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'hbfc00000, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'hbfc00004, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'hbfc00008, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'hbfc0000c, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'hbfc00010, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, 32'hbfc00100, 32'hbfc00100, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'hbfc00104, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 32'h0,        1, 32'h80000040, 32'hbfc00104, 1, 0, 1));
    tbl.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        32'hbfc00104, 1, 0, 1));
    tbl.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        32'hbfc00104, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h80000040, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h80000044, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 32'h0,        1, 32'h90000000, 32'h80000044, 1, 0, 1));
    tbl.push_back(mk(1, 1, 0, 32'h0,        1, 32'ha0000000, 32'h80000044, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'ha0000000, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 32'h0,        1, 32'hb0000000, 32'ha0000000, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, 32'hc0000000, 32'hc0000000, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'hc0000004, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 32'h0,        1, 32'h80000040, 32'hc0000004, 1, 0, 1));
    tbl.push_back(mk(1, 1, 1, 32'hbfc00380, 1, 32'h12345678, 32'hbfc00380, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        32'hbfc00380, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'hbfc00384, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'hbfc00388, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, 32'h80000002, 32'h80000002, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h80000006, 0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 32'h80000100, 0, 32'h0,        32'h80000100, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, 32'hfffffffc, 32'hfffffffc, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h00000000, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h00000004, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 32'h0,        1, 32'h80000040, 32'h00000004, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        32'hbfc00000, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 32'h0,        1, 32'h11111110, 32'hbfc00000, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'hbfc00004, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'hbfc00000, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 32'h80000180, 0, 32'h0,        32'h80000180, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h80000184, 1, 0, 0));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);
    // flush arriving on the release cycle discards the buffered branch
    apply(mk(1, 1, 0, 32'h0,        1, 32'h90000000, 32'h80000184, 1, 0, 1), 100);
    apply(mk(1, 0, 1, 32'h80000200, 0, 32'h0,        32'h80000200, 1, 0, 0), 101);
    apply(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h80000204, 1, 0, 0), 102);
    // reset held across a buffered redirect clears it; stall ignored in boot
    apply(mk(1, 1, 0, 32'h0,        1, 32'h70000000, 32'h80000204, 1, 0, 1), 103);
    apply(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'hbfc00000, 0, 0, 0), 104);
    apply(mk(1, 1, 0, 32'h0,        0, 32'h0,        32'hbfc00000, 1, 0, 0), 105);
    apply(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'hbfc00004, 1, 0, 0), 106);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard leftover %0d expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
